// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Definitions shared by the Morse digit encoder and decoder.
//   - dec_state_t    : decoder FSM states
//   - morse_to_digit : 5-element pattern (MSB first, 1 = dash) -> {valid, digit}
//   - timing constants, so both ends of the link derive from the same values
// No ports (package).
// -----------------------------------------------------------------------------
package morse_pkg;

    localparam int unsigned MORSE_CLK_FREQ = 100_000_000;

    // Encoder side: element lengths and gaps
    localparam int unsigned MORSE_DOT_CYCLES       = MORSE_CLK_FREQ;        // 1 s
    localparam int unsigned MORSE_DASH_CYCLES      = MORSE_CLK_FREQ * 3;    // 3 s
    localparam int unsigned MORSE_ELEM_GAP_CYCLES  = MORSE_CLK_FREQ / 2;    // 0.5 s
    localparam int unsigned MORSE_DIGIT_GAP_CYCLES = MORSE_CLK_FREQ * 10;   // 10 s

    // Decoder side: thresholds sit between the encoder values above
    localparam int unsigned MORSE_MIN_MARK_CYCLES   = 1_000_000;            // 10 ms
    localparam int unsigned MORSE_DASH_MIN_CYCLES   = MORSE_CLK_FREQ * 2;
    localparam int unsigned MORSE_LONG_MARK_CYCLES  = MORSE_CLK_FREQ * 6;
    localparam int unsigned MORSE_DEC_GAP_CYCLES    = MORSE_CLK_FREQ * 5;
    localparam int unsigned MORSE_DEBOUNCE_CYCLES   = 500_000;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StSpace,
        StEmit,
        StAbort
    } dec_state_t;

    // Returns {valid, digit}; valid = 0 for patterns outside the digit table.
    function automatic logic [4:0] morse_to_digit(input logic [4:0] pattern);
        logic [4:0] result;
        case (pattern)
            5'b11111: result = {1'b1, 4'd0};
            5'b01111: result = {1'b1, 4'd1};
            5'b00111: result = {1'b1, 4'd2};
            5'b00011: result = {1'b1, 4'd3};
            5'b00001: result = {1'b1, 4'd4};
            5'b00000: result = {1'b1, 4'd5};
            5'b10000: result = {1'b1, 4'd6};
            5'b11000: result = {1'b1, 4'd7};
            5'b11100: result = {1'b1, 4'd8};
            5'b11110: result = {1'b1, 4'd9};
            default:  result = 5'b0_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/morse_key_conditioner.sv
// -----------------------------------------------------------------------------
// morse_key_conditioner
// Brings the asynchronous key line into the clock domain, optionally debounces
// it, and produces single-cycle edge strobes.
// Optional debouncer: enabled by defining MORSE_DEC_DEBOUNCE_EN.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   i_key   asynchronous key line (1 = mark)
//   o_ks    conditioned key level
//   o_rise  one-cycle strobe, o_ks went 0 -> 1
//   o_fall  one-cycle strobe, o_ks went 1 -> 0
// -----------------------------------------------------------------------------
module morse_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_ks,
    output logic o_rise,
    output logic o_fall
);

`ifdef MORSE_DEC_DEBOUNCE_EN
    localparam bit LP_DB_EN = 1'b1;
`else
    localparam bit LP_DB_EN = 1'b0;
`endif

    logic [1:0] r_sync;
    logic       r_ks_prev;
    logic       w_ks;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    if (LP_DB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_db
        localparam logic [31:0] LP_DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
        logic        r_db_ks;
        logic [31:0] r_db_cnt;

        // Counter runs only while the synchronized level differs from the
        // accepted one; any return to the old level restarts the qualification.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_db_ks  <= 1'b0;
                r_db_cnt <= 32'd0;
            end else if (r_sync[1] == r_db_ks) begin
                r_db_cnt <= 32'd0;
            end else if (r_db_cnt >= LP_DB_LAST) begin
                r_db_ks  <= r_sync[1];
                r_db_cnt <= 32'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 32'd1;
            end
        end
        assign w_ks = r_db_ks;
    end else begin : g_raw
        assign w_ks = r_sync[1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ks_prev <= 1'b0;
        end else begin
            r_ks_prev <= w_ks;
        end
    end

    assign o_ks   = w_ks;
    assign o_rise = w_ks & ~r_ks_prev;
    assign o_fall = ~w_ks & r_ks_prev;

endmodule

// File: rtl/morse_code_decoder.sv
// -----------------------------------------------------------------------------
// morse_code_decoder
// Times marks and spaces on a key line, classifies marks as dot/dash and
// decodes each 5-element group into a decimal digit.
// Optional debouncer on the key line: define MORSE_DEC_DEBOUNCE_EN.
// Ports:
//   i_clk            system clock
//   i_rst            synchronous active-high reset
//   i_key_in         asynchronous key line (1 = mark)
//   o_digit_out      last decoded digit, held until the next valid decode
//   o_digit_valid    one-cycle pulse when o_digit_out is updated
//   o_error          one-cycle pulse for a rejected digit
//   o_busy           high whenever the FSM is not idle
//   o_element_count  elements received in the current digit (0-5)
// -----------------------------------------------------------------------------
module morse_code_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = MORSE_CLK_FREQ,
    parameter int unsigned MIN_MARK_CYCLES  = MORSE_MIN_MARK_CYCLES,
    parameter int unsigned DASH_MIN_CYCLES  = CLK_FREQ * 2,
    parameter int unsigned LONG_MARK_CYCLES = CLK_FREQ * 6,
    parameter int unsigned DIGIT_GAP_CYCLES = CLK_FREQ * 5,
    parameter int unsigned DEBOUNCE_CYCLES  = MORSE_DEBOUNCE_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_in,
    output logic [3:0] o_digit_out,
    output logic       o_digit_valid,
    output logic       o_error,
    output logic       o_busy,
    output logic [2:0] o_element_count
);

    localparam logic [31:0] LP_MIN  = 32'(MIN_MARK_CYCLES);
    localparam logic [31:0] LP_DASH = 32'(DASH_MIN_CYCLES);
    localparam logic [31:0] LP_LONG = 32'(LONG_MARK_CYCLES);
    localparam logic [31:0] LP_GAP  = 32'(DIGIT_GAP_CYCLES);

    logic w_ks, w_rise, w_fall;

    morse_key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_key  (i_key_in),
        .o_ks   (w_ks),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    dec_state_t  r_state, w_state_nxt;
    logic [31:0] r_timer, w_timer_nxt;
    logic [4:0]  r_pattern, w_pattern_nxt;
    logic [2:0]  r_count, w_count_nxt;
    logic [3:0]  r_digit, w_digit_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_error, w_error_nxt;
    logic        r_busy;
    logic [4:0]  w_decode;

    assign w_decode = morse_to_digit(r_pattern);

    // Pulses are registered on the transition that causes them, so
    // o_digit_valid/o_error are high during the EMIT (or first ABORT/IDLE) cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pattern_nxt = r_pattern;
        w_count_nxt   = r_count;
        w_digit_nxt   = r_digit;
        w_valid_nxt   = 1'b0;
        w_error_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_nxt = StMark;
                    w_timer_nxt = 32'd1;
                end
            end
            StMark: begin
                if (r_timer >= LP_LONG) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = StAbort;
                end else if (w_fall) begin
                    if (r_timer < LP_MIN) begin
                        // Glitch: drop it, resume the digit if one is in progress
                        w_state_nxt = (r_count != 3'd0) ? StSpace : StIdle;
                        w_timer_nxt = 32'd0;
                    end else if (r_count == 3'd5) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_pattern_nxt = {r_pattern[3:0], (r_timer >= LP_DASH)};
                        w_count_nxt   = r_count + 3'd1;
                        w_state_nxt   = StSpace;
                        w_timer_nxt   = 32'd0;
                    end
                end else if (r_timer != 32'hFFFF_FFFF) begin
                    w_timer_nxt = r_timer + 32'd1;
                end
            end
            StSpace: begin
                if (r_timer >= LP_GAP) begin
                    w_state_nxt = StEmit;
                    if ((r_count == 3'd5) && w_decode[4]) begin
                        w_digit_nxt = w_decode[3:0];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end else if (w_rise) begin
                    w_state_nxt = StMark;
                    w_timer_nxt = 32'd1;
                end else begin
                    w_timer_nxt = r_timer + 32'd1;
                end
            end
            StEmit: begin
                w_state_nxt = StIdle;
            end
            StAbort: begin
                if (!w_ks) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // IDLE always holds a clean slate
        if (w_state_nxt == StIdle) begin
            w_timer_nxt   = 32'd0;
            w_pattern_nxt = 5'd0;
            w_count_nxt   = 3'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_timer   <= 32'd0;
            r_pattern <= 5'd0;
            r_count   <= 3'd0;
            r_digit   <= 4'd0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pattern <= w_pattern_nxt;
            r_count   <= w_count_nxt;
            r_digit   <= w_digit_nxt;
            r_valid   <= w_valid_nxt;
            r_error   <= w_error_nxt;
            r_busy    <= (w_state_nxt != StIdle);
        end
    end

    assign o_digit_out     = r_digit;
    assign o_digit_valid   = r_valid;
    assign o_error         = r_error;
    assign o_busy          = r_busy;
    assign o_element_count = r_count;

endmodule
